// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the memory access unit.
// The MEM_AMO_EN macro adds the AMO_WB state used by atomic read-modify-write.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_SFENCE = 3'd3,
    OP_AMO    = 3'd4
  } memop_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } memsize_t;

  typedef enum logic [3:0] {
    AMO_SWAP = 4'd0,
    AMO_ADD  = 4'd1,
    AMO_XOR  = 4'd2,
    AMO_AND  = 4'd3,
    AMO_OR   = 4'd4,
    AMO_MIN  = 4'd5,
    AMO_MAX  = 4'd6,
    AMO_MINU = 4'd7,
    AMO_MAXU = 4'd8
  } amo_func_t;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

`ifdef MEM_AMO_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_AMO_WB} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT} state_t;
`endif

  function automatic int size_bytes(logic [1:0] s);
    return 1 << s;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_mask(logic [1:0] s);
    return 3'(size_bytes(s) - 1);
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Byte-lane steering: store data/strobe generation and load extraction/extension.
// Lane k occupies bus bits [DATA_W-1-8k -: 8]; values are little-endian across lanes.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] off_i,
  input  logic [1:0]                  size_i,
  input  logic                        uns_i,
  input  logic [DATA_W-1:0]           st_val_i,
  input  logic [DATA_W-1:0]           ld_bus_i,
  output logic [DATA_W-1:0]           st_data_o,
  output logic [DATA_W/8-1:0]         st_strb_o,
  output logic [DATA_W-1:0]           ld_val_o
);

  localparam int NBYTES = DATA_W / 8;

  int                nb;
  int                top;
  logic [DATA_W-1:0] ld_raw;
  logic              ld_sign;

  assign nb  = size_bytes(size_i);
  assign top = (8 * nb > DATA_W) ? DATA_W : 8 * nb;

  always_comb begin
    st_data_o = '0;
    st_strb_o = '0;
    for (int j = 0; j < NBYTES; j++) begin
      if (j < nb && int'(off_i) + j < NBYTES) begin
        st_data_o[DATA_W-1-8*(int'(off_i)+j) -: 8] = st_val_i[8*j +: 8];
        st_strb_o[NBYTES-1-int'(off_i)-j]          = 1'b1;
      end
    end
  end

  always_comb begin
    ld_raw = '0;
    for (int j = 0; j < NBYTES; j++) begin
      if (j < nb && int'(off_i) + j < NBYTES) begin
        ld_raw[8*j +: 8] = ld_bus_i[DATA_W-1-8*(int'(off_i)+j) -: 8];
      end
    end
  end

  always_comb begin
    ld_sign  = !uns_i && ld_raw[top-1];
    ld_val_o = ld_raw;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= top) ld_val_o[i] = ld_sign;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: one load/store/fence per enabled pulse over a single-outstanding bus.
// Define MEM_AMO_EN to add atomic read-modify-write operations (AMO_WB state).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enabled,
  input  logic [2:0]          op,
  input  logic [1:0]          size,
  input  logic                is_unsigned,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic [DATA_W-1:0]   wdata_in,
  input  logic [3:0]          amo_func,
  output logic                completed,
  output logic [DATA_W-1:0]   result,
  output logic                fault,
  output logic                flush_tlb,
  output logic                request_enable,
  output logic                mode,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                response_enable,
  input  logic [DATA_W-1:0]   data
);

  localparam int NBYTES = DATA_W / 8;
  localparam int OFF_W  = $clog2(NBYTES);

  state_t              state_q, state_d;
  logic                completed_q, completed_d;
  logic                fault_q, fault_d;
  logic                flush_q, flush_d;
  logic                req_q, req_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NBYTES-1:0]   wstrb_q, wstrb_d;

  // Operation context captured at acceptance, used while waiting on the bus.
  memop_t              op_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [OFF_W-1:0]    off_q;

  memop_t              op_e;
  logic                misaligned;
  logic                size_ok;
  logic                bad_access;
  logic [ADDR_W-1:0]   addr_al;
  logic                idle;

  logic [OFF_W-1:0]    al_off;
  logic [1:0]          al_size;
  logic [DATA_W-1:0]   al_st_val;
  logic [DATA_W-1:0]   al_st_data;
  logic [NBYTES-1:0]   al_strb;
  logic [DATA_W-1:0]   al_ld_val;

  assign op_e       = memop_t'(op);
  assign idle       = (state_q == ST_IDLE);
  assign misaligned = |(addr_in[2:0] & size_mask(size));
  assign size_ok    = (size != SZ_D) || (DATA_W == 64);
  assign bad_access = misaligned || !size_ok;
  assign addr_al    = {addr_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // In IDLE the aligner sees the incoming request; afterwards the captured context.
  assign al_off  = idle ? addr_in[OFF_W-1:0] : off_q;
  assign al_size = idle ? size : size_q;

`ifdef MEM_AMO_EN
  logic [DATA_W-1:0] opnd_q;
  logic [DATA_W-1:0] old_q;
  amo_func_t         func_q;
  logic [DATA_W-1:0] amo_b;
  logic [DATA_W-1:0] amo_new;
  logic              func_ok;

  assign func_ok   = (amo_func <= 4'd8);
  assign al_st_val = idle ? wdata_in : amo_new;

  // Word AMOs on a wide bus operate on the sign-extended 32-bit operand.
  always_comb begin
    amo_b = opnd_q;
    if (size_q == SZ_W) begin
      for (int i = 32; i < DATA_W; i++) amo_b[i] = opnd_q[31];
    end
  end

  always_comb begin
    amo_new = amo_b;
    case (func_q)
      AMO_SWAP: amo_new = amo_b;
      AMO_ADD:  amo_new = al_ld_val + amo_b;
      AMO_XOR:  amo_new = al_ld_val ^ amo_b;
      AMO_AND:  amo_new = al_ld_val & amo_b;
      AMO_OR:   amo_new = al_ld_val | amo_b;
      AMO_MIN:  amo_new = ($signed(al_ld_val) < $signed(amo_b)) ? al_ld_val : amo_b;
      AMO_MAX:  amo_new = ($signed(al_ld_val) > $signed(amo_b)) ? al_ld_val : amo_b;
      AMO_MINU: amo_new = (al_ld_val < amo_b) ? al_ld_val : amo_b;
      AMO_MAXU: amo_new = (al_ld_val > amo_b) ? al_ld_val : amo_b;
      default:  amo_new = amo_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (idle && enabled) begin
      opnd_q <= wdata_in;
      func_q <= amo_func_t'(amo_func);
    end
    if (state_q == ST_WAIT && response_enable) old_q <= al_ld_val;
  end
`else
  logic unused_amo;
  assign unused_amo = ^amo_func;
  assign al_st_val  = wdata_in;
`endif

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .off_i     (al_off),
    .size_i    (al_size),
    .uns_i     (uns_q),
    .st_val_i  (al_st_val),
    .ld_bus_i  (data),
    .st_data_o (al_st_data),
    .st_strb_o (al_strb),
    .ld_val_o  (al_ld_val)
  );

  always_ff @(posedge clk) begin
    if (idle && enabled) begin
      op_q   <= op_e;
      size_q <= size;
      uns_q  <= is_unsigned && (op_e == OP_LOAD);
      off_q  <= addr_in[OFF_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      completed_q <= 1'b0;
      fault_q     <= 1'b0;
      flush_q     <= 1'b0;
      req_q       <= 1'b0;
      mode_q      <= MEMREQ_READ;
      result_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      completed_q <= completed_d;
      fault_q     <= fault_d;
      flush_q     <= flush_d;
      req_q       <= req_d;
      mode_q      <= mode_d;
      result_q    <= result_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    completed_d = 1'b0;
    fault_d     = 1'b0;
    req_d       = 1'b0;
    flush_d     = flush_q;
    mode_d      = mode_q;
    result_d    = result_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (enabled) begin
          case (op_e)
            OP_NONE: begin
              completed_d = 1'b1;
              result_d    = wdata_in;
            end
            OP_LOAD, OP_STORE: begin
              if (bad_access) begin
                completed_d = 1'b1;
                fault_d     = 1'b1;
              end else begin
                req_d   = 1'b1;
                mode_d  = (op_e == OP_STORE) ? MEMREQ_WRITE : MEMREQ_READ;
                addr_d  = addr_al;
                wdata_d = (op_e == OP_STORE) ? al_st_data : '0;
                wstrb_d = (op_e == OP_STORE) ? al_strb : '0;
                state_d = ST_WAIT;
              end
            end
            OP_SFENCE: begin
              req_d   = 1'b1;
              mode_d  = MEMREQ_READ;
              addr_d  = '0;
              wdata_d = '0;
              wstrb_d = '0;
              flush_d = 1'b1;
              state_d = ST_WAIT;
            end
`ifdef MEM_AMO_EN
            OP_AMO: begin
              if (bad_access || size < SZ_W || !func_ok) begin
                completed_d = 1'b1;
                fault_d     = 1'b1;
              end else begin
                req_d   = 1'b1;
                mode_d  = MEMREQ_READ;
                addr_d  = addr_al;
                wdata_d = '0;
                wstrb_d = '0;
                state_d = ST_WAIT;
              end
            end
`endif
            default: begin
              completed_d = 1'b1;
              fault_d     = 1'b1;
            end
          endcase
        end
      end
      ST_WAIT: begin
        if (response_enable) begin
`ifdef MEM_AMO_EN
          if (op_q == OP_AMO) begin
            req_d   = 1'b1;
            mode_d  = MEMREQ_WRITE;
            wdata_d = al_st_data;
            wstrb_d = al_strb;
            state_d = ST_AMO_WB;
          end else
`endif
          begin
            completed_d = 1'b1;
            flush_d     = 1'b0;
            if (op_q == OP_LOAD) result_d = al_ld_val;
            state_d     = ST_IDLE;
          end
        end
      end
`ifdef MEM_AMO_EN
      ST_AMO_WB: begin
        if (response_enable) begin
          completed_d = 1'b1;
          result_d    = old_q;
          state_d     = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign completed      = completed_q;
  assign result         = result_q;
  assign fault          = fault_q;
  assign flush_tlb      = flush_q;
  assign request_enable = req_q;
  assign mode           = mode_q;
  assign addr           = addr_q;
  assign wdata          = wdata_q;
  assign wstrb          = wstrb_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised memory-stage access unit, the successor to the single-width mem stage. It accepts one load, store, fence or (optionally) atomic operation per `enabled` pulse and drives the single-outstanding-request data bus. It aligns byte lanes for DATA_W of 32 or 64, detects misaligned accesses, and returns a sign- or zero-extended result with a one-cycle `completed` pulse. It sits between exec and writeback and shares the bus/MMU port with the existing memory stage.

Parameters:
DATA_W, 32, bus and register width; legal values 32 or 64.
ADDR_W, 32, address width.
NBYTES, DATA_W/8, derived number of byte lanes (localparam).

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
enabled  in  1  start; sampled only in IDLE
op  in  3  0 NONE, 1 LOAD, 2 STORE, 3 SFENCE, 4 AMO
size  in  2  0 B, 1 H, 2 W, 3 D (D legal only when DATA_W=64)
is_unsigned  in  1  load zero-extension
addr_in  in  ADDR_W  effective address
wdata_in  in  DATA_W  store data / AMO operand / NONE pass-through
amo_func  in  4  AMO operation select
completed  out  1  one-cycle done pulse
result  out  DATA_W  load/AMO/pass-through result; held between completions
fault  out  1  valid with completed: misaligned or unsupported operation
flush_tlb  out  1  high during SFENCE
request_enable  out  1  one-cycle bus request pulse
mode  out  1  MEMREQ_READ / MEMREQ_WRITE
addr  out  ADDR_W  bus address, aligned down to NBYTES
wdata  out  DATA_W  bus write data
wstrb  out  NBYTES  byte strobes
response_enable  in  1  bus completion
data  in  DATA_W  bus read data

Behaviour:
- Reset (rstn=0 at posedge clk):
  - every output is 0; state is IDLE.
  - an in-flight request is abandoned.
  - a response_enable arriving after reset is ignored.
- States: IDLE, WAIT, AMO_WB (AMO_WB exists only with the optional feature).
- IDLE with enabled=1:
  - NONE: next cycle completed=1, result=wdata_in, fault=0.
  - Misaligned (addr_in mod 2^size != 0) or illegal size: next cycle completed=1, fault=1; no bus request; result unchanged.
  - LOAD / STORE / SFENCE: next cycle request_enable=1 for exactly one cycle; state becomes WAIT.
- enabled outside IDLE is ignored.
- Byte-lane mapping:
  - byte offset k = addr_in[log2(NBYTES)-1:0] maps to bus bits [DATA_W-1-8k -: 8].
  - multi-byte values are stored little-endian, i.e. bytes are swapped relative to lane order.
- Store:
  - mode=WRITE; addr=addr_in aligned down.
  - wstrb is set for lanes k..k+2^size-1.
  - wdata carries the LE bytes of wdata_in in those lanes and 0 elsewhere.
- Load:
  - mode=READ, wstrb=0.
  - on response, the bytes are extracted, reassembled LE, and sign-extended (or zero-extended if is_unsigned) to DATA_W.
- SFENCE:
  - flush_tlb=1 from the acceptance cycle until completion.
  - issues a dummy READ at address 0.
- WAIT:
  - request_enable returns to 0.
  - on response_enable: completed=1 and result updated in the following cycle; state returns to IDLE.
  - a response may arrive in the same cycle request_enable is high.
- Minimum latency (enabled to completed) is 2 cycles.
- completed, fault and request_enable are never high for more than one cycle.

Optional Feature:
MEM_AMO_EN.
- Defined:
  - AMO with size W (or D at DATA_W=64) performs a READ.
  - On response it computes new = f(old, wdata_in), where amo_func is 0 SWAP, 1 ADD, 2 XOR, 3 AND, 4 OR, 5 MIN, 6 MAX, 7 MINU, 8 MAXU.
  - It then enters AMO_WB and issues a WRITE pulse with full-word strobes, for word AMOs on a 64-bit bus the strobes of the word's 4 lanes.
  - On the write response it completes with result = old, sign-extended.
  - An undefined amo_func completes with fault=1 and no write.
- Undefined: op AMO completes next cycle with fault=1 and no bus activity.

Decomposition:
- Shared package (def.sv): memop_t, memsize_t, amo_func_t enums; MEMREQ_READ/MEMREQ_WRITE constants.
- Sub-module mem_lane_align: combinational store lane/strobe generation and load extraction/extension, parametrised by DATA_W.
- The FSM stays in mem_access_unit.

Test Plan:
- DATA_W=32, STORE B, addr 0x1003, wdata_in 0xAB -> addr 0x1000, wstrb 0001, wdata 0x000000AB, mode WRITE.
- LOAD H, addr 0x2002, data 0x123480FF -> result 0xFFFFFF80; with is_unsigned=1 -> 0x0000FF80.
- STORE W, addr 0x3000, wdata_in 0x11223344 -> wdata 0x44332211, wstrb 1111; completed one cycle after response_enable.
- LOAD W, addr 0x4002 -> completed=1, fault=1 the next cycle; request_enable never asserted.
- Reset asserted while in WAIT, then response_enable pulsed -> completed stays 0, all outputs 0; enabled asserted during WAIT is ignored.
- MEM_AMO_EN, AMO ADD, addr 0x5000, read data 0x05000000, wdata_in 3 -> WRITE wdata 0x08000000, wstrb 1111, result 0x00000005.
